// File: rtl/uart_frame_pkg.sv
// Shared definitions for the BL616 link frame transmitter: sync byte, frame
// type codes and the transmit FSM state encoding.
package uart_frame_pkg;

  localparam logic [7:0] SYNC            = 8'hAA;
  localparam logic [7:0] TYPE_MOUSE_HOST = 8'h06;
  localparam logic [7:0] TYPE_DEBUG      = 8'h07;
  localparam logic [7:0] TYPE_KBD        = 8'h0C;
  localparam logic [7:0] TYPE_MOUSE      = 8'h0E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AA,
    ST_LENH,
    ST_LENL,
    ST_TYPE,
    ST_DATA,
    ST_DONE
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy count and a registered full flag.
module byte_fifo #(
  parameter int DEPTH = 256,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic          do_wr, do_rd;

  // Full is judged on the count at the start of the cycle, so a pop never frees room for a same-cycle write.
  assign do_wr = wr_en_i && !full_q;
  assign do_rd = rd_en_i && (count_q != '0);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  // NOTE: storage has no reset so it maps onto RAM; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: batches bulk bytes into 0xAA/len/type/payload frames
// and interleaves single-byte priority messages between frames.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int          DEPTH        = 256,
  parameter int          MAX_PAYLOAD  = 64,
  parameter int          FLUSH_CYCLES = 20000,
  parameter logic [7:0]  BULK_TYPE    = 8'h07
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_we,
  output logic       in_full,
  output logic       in_ovf,
  input  logic       msg_valid,
  input  logic [7:0] msg_type,
  input  logic [7:0] msg_data,
  output logic       msg_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            TW      = $clog2(FLUSH_CYCLES + 2);
  localparam logic [CW-1:0] MAXP    = CW'(MAX_PAYLOAD);
  localparam logic [TW-1:0] FLUSH_T = TW'(FLUSH_CYCLES);

  state_e        state_q;
  logic [7:0]    type_q, msg_byte_q, tx_data_q, tx_byte;
  logic [15:0]   len_q, cnt_q;
  logic          is_msg_q, tx_start_q, msg_ready_q, ovf_q;
  logic [TW-1:0] timer_q;

  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count, n_bulk;
  logic          fifo_full, fifo_empty, fifo_pop, wr_ok, fire, flush_go;

  byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .wr_en_i   (in_we),
    .wr_data_i (in_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign wr_ok    = in_we && !fifo_full;
  // A byte may only go out when the transmitter is free and no start pulse is still in flight.
  assign fire     = !tx_busy && !tx_start_q;
  assign flush_go = (fifo_count >= MAXP) || (!fifo_empty && (timer_q >= FLUSH_T));
  assign n_bulk   = (fifo_count >= MAXP) ? MAXP : fifo_count;
  assign fifo_pop = (state_q == ST_DATA) && fire && !is_msg_q;

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      ST_AA:   tx_byte = SYNC;
      ST_LENH: tx_byte = len_q[15:8];
      ST_LENL: tx_byte = len_q[7:0];
      ST_TYPE: tx_byte = type_q;
      ST_DATA: tx_byte = is_msg_q ? msg_byte_q : fifo_rdata;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (in_we && fifo_full) ovf_q <= 1'b1;
      if (wr_ok || fifo_empty)  timer_q <= '0;
      else if (timer_q != '1)   timer_q <= timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      type_q      <= 8'h00;
      msg_byte_q  <= 8'h00;
      len_q       <= 16'h0000;
      cnt_q       <= 16'h0000;
      is_msg_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      msg_ready_q <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      msg_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (msg_valid) begin
            type_q      <= msg_type;
            msg_byte_q  <= msg_data;
            is_msg_q    <= 1'b1;
            len_q       <= 16'd2;
            cnt_q       <= 16'd1;
            msg_ready_q <= 1'b1;
            state_q     <= ST_AA;
          end else if (flush_go) begin
            type_q   <= BULK_TYPE;
            is_msg_q <= 1'b0;
            len_q    <= 16'(n_bulk) + 16'd1;
            cnt_q    <= 16'(n_bulk);
            state_q  <= ST_AA;
          end
        end
        ST_AA, ST_LENH, ST_LENL, ST_TYPE: begin
          if (fire) begin
            tx_data_q  <= tx_byte;
            tx_start_q <= 1'b1;
            case (state_q)
              ST_AA:   state_q <= ST_LENH;
              ST_LENH: state_q <= ST_LENL;
              ST_LENL: state_q <= ST_TYPE;
              default: state_q <= ST_DATA;
            endcase
          end
        end
        ST_DATA: begin
          if (fire) begin
            tx_data_q  <= tx_byte;
            tx_start_q <= 1'b1;
            if (cnt_q == 16'd1) state_q <= ST_DONE;
            else                cnt_q   <= cnt_q - 16'd1;
          end
        end
        ST_DONE: begin
          if (fire) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_full   = fifo_full;
  assign in_ovf    = ovf_q;
  assign msg_ready = msg_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
